// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the two buses around the fetch stage:
//     - instruction memory side : imem_req/imem_addr out, imem_gnt/imem_rvalid/
//                                 imem_rdata back
//     - controller side         : instr_valid/instr/pc/pc_plus4/op/funct3/
//                                 funct7b5/fetch_err out, instr_ready/PCSrc/
//                                 PCTarget back
//   master : the fetch stage itself
//   slave  : the environment (instruction memory + decode controller)
// ----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    // instruction memory request/response
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    // instruction handoff to the controller
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;

    // redirect from the controller and error status back to it
    logic            PCSrc;
    logic [XLEN-1:0] PCTarget;
    logic            fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, pc, pc_plus4, op, funct3, funct7b5,
        input  instr_ready,
        input  PCSrc, PCTarget,
        output fetch_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, pc, pc_plus4, op, funct3, funct7b5,
        output instr_ready,
        output PCSrc, PCTarget,
        input  fetch_err
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding the main/ALU decode controller.
//   Holds the PC, fetches one instruction at a time over a req/gnt/rvalid
//   memory handshake, latches it and offers it downstream on valid/ready
//   together with its pc, pc+4 and the op/funct3/funct7b5 decode slices.
//   At the downstream handshake the next PC is chosen from PC+4 or the
//   PCSrc/PCTarget redirect; a taken redirect to a non word-aligned target
//   parks the stage in a sticky error state until reset.
//
// Ports
//   clk    : core clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_stage_if.master (memory + controller signals)
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.master  bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [2:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            err_q;

    // Only a taken redirect can be misaligned; the sequential path is
    // always word aligned because PC starts aligned and advances by 4.
    logic redirect_misaligned;
    assign redirect_misaligned = bus.PCSrc && (bus.PCTarget[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            err_q   <= 1'b0;
        end else begin
            case (state)
                // One dead cycle after reset so the memory, which shares our
                // reset, is out of reset before we ask it for anything.
                IDLE: state <= REQ;

                REQ: begin
                    if (bus.imem_gnt) begin
                        if (bus.imem_rvalid) begin
                            instr_q <= bus.imem_rdata;
                            state   <= HOLD;
                        end else begin
                            state   <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_q <= bus.imem_rdata;
                        state   <= HOLD;
                    end
                end

                // PCSrc/PCTarget only matter at this handshake.
                HOLD: begin
                    if (bus.instr_ready) begin
                        if (redirect_misaligned) begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end else begin
                            pc_q  <= bus.PCSrc ? bus.PCTarget : pc_q + XLEN'(4);
                            state <= REQ;
                        end
                    end
                end

                ERR: state <= ERR;

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req    = (state == REQ);
    assign bus.imem_addr   = pc_q;

    assign bus.instr_valid = (state == HOLD);
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + XLEN'(4);
    assign bus.op          = instr_q[6:0];
    assign bus.funct3      = instr_q[14:12];
    assign bus.funct7b5    = instr_q[30];

    assign bus.fetch_err   = err_q;

endmodule
